// File: rtl/mmio_pwm_leds_if.sv
// Data-bus connection between the core's load/store port (master) and a
// memory-mapped responder (slave).
//   bus_req   : request strobe, one transfer per asserted cycle
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : byte address, bits [1:0] ignored by responders
//   bus_wdata : write data
//   bus_be    : byte enables for writes, bit n gates bus_wdata[8n+7:8n]
//   bus_rdata : read data, valid while bus_ready=1, otherwise 0
//   bus_ready : one-cycle response strobe, one cycle after an accepted request
interface mmio_pwm_leds_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/mmio_pwm_leds.sv
// Memory-mapped 8-bit PWM driver for the board LED and RGB pins.
// Answers CPU load/store requests inside an 8-word window at BASE_ADDR and
// generates four PWM waveforms from a shared prescaled 255-step phase counter.
// Ports:
//   clk              : system clock
//   reset            : synchronous, active-low reset
//   bus              : data-bus slave port (see mmio_pwm_leds_if)
//   led              : PWM output, active-high
//   red/green/blue   : PWM outputs, active-low when RGB_ACTIVE_LOW=1
// Register map (word offsets from BASE_ADDR):
//   0x00 CTRL[0] enable      0x04 LED_DUTY[7:0]   0x08 RED_DUTY[7:0]
//   0x0C GRN_DUTY[7:0]       0x10 BLU_DUTY[7:0]   0x14 PRESCALE[15:0]
//   0x18 PERIODS[31:0] (RO)  0x1C reserved (reads 0)
module mmio_pwm_leds #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter logic        RGB_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    mmio_pwm_leds_if.slave  bus,
    output logic            led,
    output logic            red,
    output logic            green,
    output logic            blue
);

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_LED      = 3'd1;
    localparam logic [2:0] IDX_RED      = 3'd2;
    localparam logic [2:0] IDX_GRN      = 3'd3;
    localparam logic [2:0] IDX_BLU      = 3'd4;
    localparam logic [2:0] IDX_PRESCALE = 3'd5;
    localparam logic [2:0] IDX_PERIODS  = 3'd6;
    localparam logic [7:0] PHASE_LAST   = 8'd254;

    // Byte-lane merge for a register write: lanes without an enable keep the old byte.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_value,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] result;
        result = old_value;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return result;
    endfunction

    // Software-visible registers
    logic        enable_r;
    logic [7:0]  led_duty_r;
    logic [7:0]  red_duty_r;
    logic [7:0]  grn_duty_r;
    logic [7:0]  blu_duty_r;
    logic [15:0] prescale_r;
    logic [31:0] periods_r;

    // Comparator shadows, only refreshed at period boundaries or on enable
    logic [7:0]  led_shadow_r;
    logic [7:0]  red_shadow_r;
    logic [7:0]  grn_shadow_r;
    logic [7:0]  blu_shadow_r;

    // Timebase
    logic [15:0] presc_cnt_r;
    logic [7:0]  phase_r;

    // Bus response and pin registers
    logic        ready_r;
    logic [31:0] rdata_r;
    logic        led_r;
    logic        red_r;
    logic        green_r;
    logic        blue_r;

    // Decoded request and timebase events
    logic        accept_s;
    logic        write_s;
    logic [2:0]  idx_s;
    logic [31:0] rd_mux_s;
    logic [31:0] prescale_merged_s;
    logic        tick_s;
    logic        wrap_s;
    logic        enable_rise_s;
    logic        led_lit_s;
    logic        red_lit_s;
    logic        grn_lit_s;
    logic        blu_lit_s;

    assign accept_s = bus.bus_req && (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign write_s  = accept_s && bus.bus_we;
    assign idx_s    = bus.bus_addr[4:2];

    assign prescale_merged_s = merge_bytes({16'h0000, prescale_r}, bus.bus_wdata, bus.bus_be);

    // The prescaler compares with equality only, so lowering PRESCALE below the
    // current count lets the counter run on to 16'hFFFF and wrap before matching.
    assign tick_s = enable_r && (presc_cnt_r == prescale_r);
    assign wrap_s = tick_s && (phase_r == PHASE_LAST);

    // Shadows load when enable goes 0->1 so the first period uses current duties.
    assign enable_rise_s = write_s && (idx_s == IDX_CTRL) && bus.bus_be[0]
                           && bus.bus_wdata[0] && !enable_r;

    // Duty 255 is always lit because phase never exceeds 254.
    assign led_lit_s = enable_r && (phase_r < led_shadow_r);
    assign red_lit_s = enable_r && (phase_r < red_shadow_r);
    assign grn_lit_s = enable_r && (phase_r < grn_shadow_r);
    assign blu_lit_s = enable_r && (phase_r < blu_shadow_r);

    // Read-data multiplexer over the register window (pre-write values)
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (idx_s)
            IDX_CTRL:     rd_mux_s = {31'h0000_0000, enable_r};
            IDX_LED:      rd_mux_s = {24'h00_0000, led_duty_r};
            IDX_RED:      rd_mux_s = {24'h00_0000, red_duty_r};
            IDX_GRN:      rd_mux_s = {24'h00_0000, grn_duty_r};
            IDX_BLU:      rd_mux_s = {24'h00_0000, blu_duty_r};
            IDX_PRESCALE: rd_mux_s = {16'h0000, prescale_r};
            IDX_PERIODS:  rd_mux_s = periods_r;
            default:      rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Control and duty register writes, byte-enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            enable_r   <= 1'b0;
            led_duty_r <= 8'h00;
            red_duty_r <= 8'h00;
            grn_duty_r <= 8'h00;
            blu_duty_r <= 8'h00;
            prescale_r <= 16'h0000;
        end else if (write_s) begin
            case (idx_s)
                IDX_CTRL: begin
                    if (bus.bus_be[0]) begin
                        enable_r <= bus.bus_wdata[0];
                    end
                end
                IDX_LED: begin
                    if (bus.bus_be[0]) begin
                        led_duty_r <= bus.bus_wdata[7:0];
                    end
                end
                IDX_RED: begin
                    if (bus.bus_be[0]) begin
                        red_duty_r <= bus.bus_wdata[7:0];
                    end
                end
                IDX_GRN: begin
                    if (bus.bus_be[0]) begin
                        grn_duty_r <= bus.bus_wdata[7:0];
                    end
                end
                IDX_BLU: begin
                    if (bus.bus_be[0]) begin
                        blu_duty_r <= bus.bus_wdata[7:0];
                    end
                end
                IDX_PRESCALE: begin
                    prescale_r <= prescale_merged_s[15:0];
                end
                default: begin
                    // PERIODS and the reserved word ignore writes
                end
            endcase
        end
    end

    // Prescaler, phase counter and completed-period counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_cnt_r <= 16'h0000;
            phase_r     <= 8'h00;
            periods_r   <= 32'h0000_0000;
        end else if (!enable_r) begin
            presc_cnt_r <= 16'h0000;
            phase_r     <= 8'h00;
        end else if (tick_s) begin
            presc_cnt_r <= 16'h0000;
            if (wrap_s) begin
                phase_r   <= 8'h00;
                periods_r <= periods_r + 32'd1;
            end else begin
                phase_r <= phase_r + 8'd1;
            end
        end else begin
            presc_cnt_r <= presc_cnt_r + 16'd1;
        end
    end

    // Duty shadows: refreshed at the 254->0 wrap or when the block is enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_shadow_r <= 8'h00;
            red_shadow_r <= 8'h00;
            grn_shadow_r <= 8'h00;
            blu_shadow_r <= 8'h00;
        end else if (wrap_s || enable_rise_s) begin
            led_shadow_r <= led_duty_r;
            red_shadow_r <= red_duty_r;
            grn_shadow_r <= grn_duty_r;
            blu_shadow_r <= blu_duty_r;
        end
    end

    // Bus response: one-cycle ready pulse with data captured at the accept edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ready_r <= accept_s;
            rdata_r <= accept_s ? rd_mux_s : 32'h0000_0000;
        end
    end

    // Registered PWM pins; RGB polarity folded in here
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_r   <= 1'b0;
            red_r   <= RGB_ACTIVE_LOW;
            green_r <= RGB_ACTIVE_LOW;
            blue_r  <= RGB_ACTIVE_LOW;
        end else begin
            led_r   <= led_lit_s;
            red_r   <= red_lit_s ^ RGB_ACTIVE_LOW;
            green_r <= grn_lit_s ^ RGB_ACTIVE_LOW;
            blue_r  <= blu_lit_s ^ RGB_ACTIVE_LOW;
        end
    end

    assign bus.bus_ready = ready_r;
    assign bus.bus_rdata = rdata_r;
    assign led   = led_r;
    assign red   = red_r;
    assign green = green_r;
    assign blue  = blue_r;

endmodule

// File: tb/tb_mmio_pwm_leds.sv
// Scoreboard bench for mmio_pwm_leds: directed scenarios followed by random
// bus traffic, checked against a behavioural model of the PWM block.
module tb_mmio_pwm_leds;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic led, red, green, blue;

    mmio_pwm_leds_if bus();

    mmio_pwm_leds #(.BASE_ADDR(BASE), .RGB_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .led   (led),
        .red   (red),
        .green (green),
        .blue  (blue)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_en;
    int          m_duty[4];
    int          m_shadow[4];
    int          m_presc;
    int          m_pc;
    int          m_phase;
    logic [31:0] m_periods;

    // Expectations for the cycle after the latest edge
    logic [3:0]  exp_pins;   // {led, red, green, blue}
    bit          exp_ready;
    logic [31:0] exp_q[$];
    bit          mon_on = 1'b0;

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0:       return {31'h0, m_en};
            1, 2, 3, 4: return 32'(m_duty[idx-1]);
            5:       return 32'(m_presc);
            6:       return m_periods;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic step(input bit r_n, input bit req, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        bit   acc;
        int   idx;
        bit   lit[4];
        logic [31:0] pv;
        if (!r_n) begin
            m_en = 1'b0; m_presc = 0; m_pc = 0; m_phase = 0; m_periods = 32'h0;
            for (int i = 0; i < 4; i++) begin m_duty[i] = 0; m_shadow[i] = 0; end
            exp_pins  = 4'b0111;
            exp_ready = 1'b0;
            exp_q.delete();
            return;
        end
        acc = req && (addr[31:5] == BASE[31:5]);
        idx = int'(addr[4:2]);
        for (int i = 0; i < 4; i++) lit[i] = m_en && (m_phase < m_shadow[i]);
        exp_pins  = {lit[0], ~lit[1], ~lit[2], ~lit[3]};
        exp_ready = acc;
        if (acc) exp_q.push_back(model_read(idx));
        if (m_en) begin
            if (m_pc == m_presc) begin
                m_pc = 0;
                if (m_phase == 254) begin
                    m_phase = 0;
                    m_periods = m_periods + 32'd1;
                    m_shadow = m_duty;
                end else begin
                    m_phase = m_phase + 1;
                end
            end else begin
                m_pc = (m_pc + 1) % 65536;
            end
        end else begin
            m_pc = 0;
            m_phase = 0;
        end
        if (acc && we) begin
            case (idx)
                0: if (be[0]) begin
                       if (!m_en && wdata[0]) m_shadow = m_duty;
                       m_en = wdata[0];
                   end
                1, 2, 3, 4: if (be[0]) m_duty[idx-1] = int'(wdata[7:0]);
                5: begin
                       pv = 32'(m_presc);
                       if (be[0]) pv[7:0]  = wdata[7:0];
                       if (be[1]) pv[15:8] = wdata[15:8];
                       m_presc = int'(pv[15:0]);
                   end
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive inputs, let the edge happen, update the model.
    task automatic cyc(input bit r_n, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
        reset         = r_n;
        bus.bus_req   = req;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        bus.bus_be    = be;
        @(posedge clk);
        step(r_n, req, we, addr, wdata, be);
        mon_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
        cyc(1'b1, 1'b1, 1'b1, BASE + off, data, be);
    endtask

    task automatic rd(input logic [31:0] off);
        cyc(1'b1, 1'b1, 1'b0, BASE + off, 32'h0, 4'h0);
    endtask

    // Monitor: compares pins every cycle and pops the scoreboard on each ready pulse.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [31:0] exp_d;
            checks++;
            if ({led, red, green, blue} !== exp_pins) begin
                errors++;
                $display("FAIL pins t=%0t got=%b exp=%b", $time, {led, red, green, blue}, exp_pins);
            end
            checks++;
            if (bus.bus_ready !== exp_ready) begin
                errors++;
                $display("FAIL ready t=%0t got=%b exp=%b", $time, bus.bus_ready, exp_ready);
            end
            if (bus.bus_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_response t=%0t got=%h exp=none", $time, bus.bus_rdata);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (bus.bus_rdata !== exp_d) begin
                        errors++;
                        $display("FAIL rdata t=%0t got=%h exp=%h", $time, bus.bus_rdata, exp_d);
                    end
                end
            end else begin
                if (exp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                checks++;
                if (bus.bus_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL rdata_idle t=%0t got=%h exp=00000000", $time, bus.bus_rdata);
                end
            end
        end
    end

    initial begin
        int cnt;
        int guard;
        bus.bus_req = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 32'h0;
        bus.bus_wdata = 32'h0; bus.bus_be = 4'h0;

        // Reset and read back every register
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) rd(32'(i * 4));

        // Red at half duty, free-running prescaler, greens off, blue full
        wr(32'h08, 32'h0000_0080, 4'b0001);
        wr(32'h0C, 32'h0000_0000, 4'b0001);
        wr(32'h10, 32'h0000_00FF, 4'b0001);
        wr(32'h14, 32'h0000_0000, 4'b0011);
        wr(32'h00, 32'h0000_0001, 4'b0001);
        idle(10);
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            idle(1);
            if (red == 1'b0) cnt++;
        end
        checks++;
        if (cnt != 128) begin
            errors++;
            $display("FAIL red_low_count got=%0d exp=128", cnt);
        end
        idle(600);
        rd(32'h18);

        // Change red duty mid-period; shadow holds until the wrap
        guard = 0;
        while (m_phase != 50 && guard < 1000) begin idle(1); guard++; end
        checks++;
        if (guard >= 1000) begin
            errors++;
            $display("FAIL phase_wait got=%0d exp=50", m_phase);
        end
        wr(32'h08, 32'h0000_0010, 4'b0001);
        rd(32'h08);
        idle(500);

        // Byte-enabled prescale writes
        wr(32'h14, 32'h0000_1234, 4'b0010);
        rd(32'h14);
        wr(32'h14, 32'h0000_1234, 4'b0001);
        rd(32'h14);

        // Out-of-window access, then reset mid-period
        rd(32'h40);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        wr(32'h04, 32'h0000_00C0, 4'b0001);
        wr(32'h00, 32'h0000_0001, 4'b0001);
        guard = 0;
        while (m_phase != 100 && guard < 1000) begin idle(1); guard++; end
        cyc(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) rd(32'(i * 4));

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [31:0] addr, wdata, pv;
            logic [3:0]  be;
            bit we;
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end else if (r < 80) begin
                if ($urandom_range(0, 9) == 0)
                    addr = (($urandom_range(0, 1) == 0) ? BASE + 32'h20 + 32'($urandom_range(0, 7) * 4)
                                                        : $urandom);
                else
                    addr = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                we    = $urandom_range(0, 1) == 1;
                wdata = $urandom;
                be    = 4'($urandom_range(0, 15));
                if (we && addr[31:5] == BASE[31:5] && addr[4:2] == 3'd5) begin
                    // Only non-decreasing small prescales, so the counter never
                    // has to run the long way round to 16'hFFFF.
                    wdata[15:0] = 16'($urandom_range(0, 3));
                    pv = 32'(m_presc);
                    if (be[0]) pv[7:0]  = wdata[7:0];
                    if (be[1]) pv[15:8] = wdata[15:8];
                    if (int'(pv) < m_presc) we = 1'b0;
                end
                cyc(1'b1, 1'b1, we, addr, wdata, be);
            end else begin
                idle(1);
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
